// File: rtl/loop_resp_pkg.sv
// Shared types and constants for the loop-body responder.
//   state_t    : RUN / DRAIN responder state
//   occ_width  : width of a counter that can hold 0..depth
package loop_resp_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/loop_idx_fifo.sv
// Synchronous index FIFO, DEPTH x IDX_DWIDTH, no bypass.
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   push, push_data    : write request and data
//   pop                : read request (advances head)
//   flush              : discard all entries (wins over push/pop)
//   head               : oldest entry
//   count, empty, full : fill status
module loop_idx_fifo
  import loop_resp_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned IDX_DWIDTH = 32,
  localparam int unsigned CNT_W     = occ_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [IDX_DWIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [IDX_DWIDTH-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [IDX_DWIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/loop_body_responder.sv
// Slave side of the looper ap handshake: queues accepted indices, issues
// them to a worker over valid/ready and returns in-order ap_done/ap_return.
// Optional macro LOOP_BREAK_FLUSH_EN: a break completion flushes queued
// indices and silently drains the remaining in-flight results.
// Ports:
//   clk, rstn                 : clock, synchronous active-low reset
//   ap_start, ap_idx, ap_ready: iteration request / accept
//   ap_done, ap_return        : registered completion pulse and break flag
//   ap_idle                   : nothing queued or in flight
//   work_valid/ready/idx      : index issue to the worker
//   res_valid, res_break      : in-order worker completion
//   occupancy                 : queued + in-flight count
module loop_body_responder
  import loop_resp_pkg::*;
#(
  parameter int unsigned IDX_DWIDTH = 32,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  localparam int unsigned OCC_W     = occ_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ap_start,
  input  logic [IDX_DWIDTH-1:0] ap_idx,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_return,
  output logic                  work_valid,
  input  logic                  work_ready,
  output logic [IDX_DWIDTH-1:0] work_idx,
  input  logic                  res_valid,
  input  logic                  res_break,
  output logic [OCC_W-1:0]      occupancy
);

  state_t           state;
  state_t           state_next;
  logic [OCC_W-1:0] q_cnt;
  logic [OCC_W-1:0] inflight;
  logic [OCC_W-1:0] inflight_next;
  logic             fifo_empty;
  logic             fifo_full;
  logic             accept;
  logic             issue;
  logic             complete;
  logic             done_set;
  logic             flush;

  loop_idx_fifo #(
    .DEPTH      (DEPTH),
    .IDX_DWIDTH (IDX_DWIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (accept),
    .push_data (ap_idx),
    .pop       (issue),
    .flush     (flush),
    .head      (work_idx),
    .count     (q_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign occupancy     = q_cnt + inflight;
  assign ap_idle       = (occupancy == '0) & (state == RUN);
  assign accept        = ap_start & ap_ready;
  assign issue         = work_valid & work_ready;
  // Results with nothing in flight are stray and ignored.
  assign complete      = res_valid & (inflight != '0);
  assign inflight_next = inflight + OCC_W'(issue) - OCC_W'(complete);

`ifdef LOOP_BREAK_FLUSH_EN
  // A pending break blocks accepts so a flushed edge never takes a new index.
  assign ap_ready   = (state == RUN) & (occupancy < OCC_W'(DEPTH)) & ~fifo_full
                      & ~(res_valid & res_break);
  assign work_valid = (state == RUN) & ~fifo_empty;
  assign done_set   = complete & (state == RUN);
  assign flush      = done_set & res_break;
`else
  assign ap_ready   = (occupancy < OCC_W'(DEPTH)) & ~fifo_full;
  assign work_valid = ~fifo_empty;
  assign done_set   = complete;
  assign flush      = 1'b0;
`endif

  // Next-state: DRAIN only entered on a break with results still in flight.
  always_comb begin
    state_next = state;
`ifdef LOOP_BREAK_FLUSH_EN
    unique case (state)
      RUN:     if (flush && (inflight_next != '0)) state_next = DRAIN;
      DRAIN:   if (inflight == '0) state_next = RUN;
      default: state_next = RUN;
    endcase
`endif
  end

  // State, in-flight counter and registered completion outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= RUN;
      inflight  <= '0;
      ap_done   <= 1'b0;
      ap_return <= 1'b0;
    end else begin
      state     <= state_next;
      inflight  <= inflight_next;
      ap_done   <= done_set;
      ap_return <= done_set & res_break;
    end
  end

endmodule

// File: tb/tb_loop_body_responder.sv
// Scoreboard bench for loop_body_responder (DEPTH=4, 32-bit indices).
module tb_loop_body_responder;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned OW = 3;

  logic          clk;
  logic          rstn;
  logic          ap_start;
  logic [W-1:0]  ap_idx;
  logic          ap_ready;
  logic          ap_done;
  logic          ap_idle;
  logic          ap_return;
  logic          work_valid;
  logic          work_ready;
  logic [W-1:0]  work_idx;
  logic          res_valid;
  logic          res_break;
  logic [OW-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_work[$];
  logic         exp_done[$];

  loop_body_responder #(.IDX_DWIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ap_start   (ap_start),
    .ap_idx     (ap_idx),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_return  (ap_return),
    .work_valid (work_valid),
    .work_ready (work_ready),
    .work_idx   (work_idx),
    .res_valid  (res_valid),
    .res_break  (res_break),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Monitor: compares issued indices and completions against the queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (work_valid && work_ready) begin
        if (exp_work.size() == 0) fail_now("work_issue_unexpected");
        else check("work_idx", work_idx, exp_work.pop_front());
      end
      if (ap_done) begin
        if (exp_done.size() == 0) fail_now("ap_done_unexpected");
        else check("ap_return", W'(ap_return), W'(exp_done.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic start(input logic [W-1:0] idx, input logic wr, input logic expect_issue);
    ap_start   = 1'b1;
    ap_idx     = idx;
    work_ready = wr;
    if (expect_issue) exp_work.push_back(idx);
  endtask

  // Issue everything queued, then return n in-order non-break results.
  task automatic drain(input int n);
    ap_start   = 1'b0;
    work_ready = 1'b1;
    repeat (D + 1) step();
    for (int i = 0; i < n; i++) begin
      res_valid = 1'b1;
      res_break = 1'b0;
      exp_done.push_back(1'b0);
      step();
    end
    res_valid = 1'b0;
    step();
    step();
    at_neg();
    check("drain_occupancy", W'(occupancy), 0);
    check("drain_idle", W'(ap_idle), 1);
    step();
  endtask

  initial begin
    rstn = 1'b0; ap_start = 1'b0; ap_idx = '0; work_ready = 1'b0;
    res_valid = 1'b0; res_break = 1'b0;
    repeat (2) step();
    at_neg();
    check("rst_ap_ready", W'(ap_ready), 1);
    check("rst_ap_idle", W'(ap_idle), 1);
    check("rst_ap_done", W'(ap_done), 0);
    check("rst_ap_return", W'(ap_return), 0);
    check("rst_work_valid", W'(work_valid), 0);
    check("rst_work_idx", work_idx, 0);
    check("rst_occupancy", W'(occupancy), 0);
    step();
    rstn = 1'b1;
    step();

    // Single iteration, worker latency 3
    start(7, 1'b1, 1'b1);
    at_neg();
    check("t1_ready", W'(ap_ready), 1);
    check("t1_no_bypass", W'(work_valid), 0);
    step();
    ap_start = 1'b0;
    at_neg();
    check("t1_work_valid", W'(work_valid), 1);
    check("t1_work_idx", work_idx, 7);
    step(); step(); step();
    res_valid = 1'b1; res_break = 1'b0; exp_done.push_back(1'b0);
    step();
    res_valid = 1'b0;
    at_neg();
    check("t1_ap_done", W'(ap_done), 1);
    step();
    at_neg();
    check("t1_idle", W'(ap_idle), 1);
    check("t1_occ", W'(occupancy), 0);
    step();

    // Back-to-back fill with worker stalled
    for (int i = 0; i < 5; i++) begin
      start(W'(i), 1'b0, 1'b0);
      at_neg();
      if (i < 4) begin
        check("t2_ready_open", W'(ap_ready), 1);
        exp_work.push_back(W'(i));
      end else begin
        check("t2_ready_full", W'(ap_ready), 0);
        check("t2_occ_full", W'(occupancy), 4);
      end
      step();
    end
    work_ready = 1'b1;
    step();
    res_valid = 1'b1; res_break = 1'b0; exp_done.push_back(1'b0);
    at_neg();
    check("t2_ready_inflight", W'(ap_ready), 0);
    step();
    res_valid = 1'b0;
    at_neg();
    check("t2_ready_reopen", W'(ap_ready), 1);
    check("t2_occ", W'(occupancy), 3);
    exp_work.push_back(4);
    step();
    drain(4);

    // Accept, issue and complete in the same cycle
    start(10, 1'b0, 1'b1);
    step();
    start(11, 1'b1, 1'b1);
    step();
    start(12, 1'b1, 1'b1);
    res_valid = 1'b1; res_break = 1'b0; exp_done.push_back(1'b0);
    at_neg();
    check("t3_occ_before", W'(occupancy), 2);
    check("t3_ready", W'(ap_ready), 1);
    step();
    ap_start = 1'b0; res_valid = 1'b0; work_ready = 1'b0;
    at_neg();
    check("t3_occ_after", W'(occupancy), 2);
    drain(2);

    // Stray result with nothing in flight
    res_valid = 1'b1; res_break = 1'b1;
    step();
    res_valid = 1'b0; res_break = 1'b0;
    at_neg();
    check("t4_no_done", W'(ap_done), 0);
    check("t4_occ", W'(occupancy), 0);
    check("t4_idle", W'(ap_idle), 1);
    step();

    // Reset mid-run with occupancy 3
    start(30, 1'b0, 1'b1);
    step();
    start(31, 1'b1, 1'b0);
    step();
    start(32, 1'b0, 1'b0);
    step();
    ap_start = 1'b0;
    rstn = 1'b0;
    at_neg();
    check("t5_occ_pre", W'(occupancy), 3);
    step();
    rstn = 1'b1;
    at_neg();
    check("t5_occ", W'(occupancy), 0);
    check("t5_ready", W'(ap_ready), 1);
    check("t5_work_valid", W'(work_valid), 0);
    check("t5_work_idx", work_idx, 0);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    at_neg();
    check("t5_late_no_done", W'(ap_done), 0);
    check("t5_occ_late", W'(occupancy), 0);
    step();

    // Break completion with 2 in flight and 2 queued
    start(20, 1'b0, 1'b1);
    step();
    start(21, 1'b1, 1'b1);
    step();
`ifdef LOOP_BREAK_FLUSH_EN
    start(22, 1'b1, 1'b0);
    step();
    start(23, 1'b0, 1'b0);
    step();
`else
    start(22, 1'b1, 1'b1);
    step();
    start(23, 1'b0, 1'b1);
    step();
`endif
    ap_start = 1'b0;
    res_valid = 1'b1; res_break = 1'b1; exp_done.push_back(1'b1);
    at_neg();
    check("t6_occ_pre", W'(occupancy), 4);
    step();
    res_valid = 1'b0; res_break = 1'b0;
    at_neg();
    check("t6_done", W'(ap_done), 1);
    check("t6_return", W'(ap_return), 1);
`ifdef LOOP_BREAK_FLUSH_EN
    check("t6_occ_flushed", W'(occupancy), 1);
    check("t6_drain_ready", W'(ap_ready), 0);
    check("t6_drain_wvalid", W'(work_valid), 0);
    check("t6_drain_idle", W'(ap_idle), 0);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    at_neg();
    check("t6_suppressed", W'(ap_done), 0);
    check("t6_occ_zero", W'(occupancy), 0);
    check("t6_still_drain", W'(ap_idle), 0);
    step();
    at_neg();
    check("t6_run_idle", W'(ap_idle), 1);
    check("t6_run_ready", W'(ap_ready), 1);
    step();
`else
    check("t6_occ_kept", W'(occupancy), 3);
    drain(3);
`endif

    repeat (3) step();
    check("exp_work_left", W'(exp_work.size()), 0);
    check("exp_done_left", W'(exp_done.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_body_responder.md
Name: loop_body_responder

Overview:
- Slave end of the looper's ap handshake: accepts ap_start/ap_idx iterations, buffers the indices and issues each to a per-index worker datapath over valid/ready.
- Returns in-order completions to the looper as ap_done/ap_return pulses.
- Sits between the loop-control block and a compute body, so the body need not implement ap_ctrl semantics.
- Supports pipelined issue, with up to DEPTH iterations outstanding.

Parameters:
- IDX_DWIDTH, 32, width of ap_idx / work_idx; matches the looper's LEN_DWIDTH.
- DEPTH, 4, maximum accepted-but-not-completed iterations; power of two, >=2.
- OCC_W, $clog2(DEPTH+1), occupancy counter width (localparam).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- ap_start  in  1  looper requests an iteration.
- ap_idx  in  IDX_DWIDTH  iteration index, valid with ap_start.
- ap_ready  out  1  iteration accepted this cycle when ap_start & ap_ready.
- ap_done  out  1  one-cycle pulse per completed iteration.
- ap_idle  out  1  no iteration queued or in flight.
- ap_return  out  1  break flag of the completing iteration; valid only with ap_done.
- work_valid  out  1  index available to worker.
- work_ready  in  1  worker takes index.
- work_idx  out  IDX_DWIDTH  index to worker.
- res_valid  in  1  worker completes the oldest issued index (in order, no backpressure).
- res_break  in  1  worker break request, valid with res_valid.
- occupancy  out  OCC_W  queued + in-flight count.

Behaviour:
- Reset: all registers clear on posedge clk while rstn=0. Output values in reset: ap_done=0, ap_return=0, work_valid=0, work_idx=0, occupancy=0, ap_ready=1, ap_idle=1. Reset mid-operation discards queued indices and in-flight counts. Worker results arriving after reset are ignored because inflight=0.
- Accept: ap_ready = (q_cnt + inflight) < DEPTH, combinational from registered counts only. It never depends on ap_start. The index is written into the FIFO on the accepting edge.
- Issue: work_valid = FIFO not empty. work_idx = FIFO head. On work_valid & work_ready: pop the FIFO, inflight += 1. There is no FIFO bypass, so an index accepted in cycle T appears on work_idx no earlier than T+1.
- Complete: on res_valid with inflight>0, inflight -= 1. ap_done is registered and pulses at the next edge; ap_return = res_break in that same cycle. Minimum latency is ap_start accept at T, res_valid at T+1+L, ap_done at T+2+L.
- res_valid with inflight=0 is a protocol violation: ignored, no ap_done, counters unchanged.
- Simultaneous events: accept, issue and complete in the same cycle all apply. q_cnt and inflight update independently, so occupancy changes by (+accept - complete).
- Occupancy: occupancy = q_cnt + inflight. It never exceeds DEPTH.
- Idle: ap_idle = (occupancy==0) & state==RUN. It is combinational from registers.
- Non-pipelined looper (waits for ap_done before the next ap_start) needs no special handling.
- State machine RUN/DRAIN: DRAIN exists only with the optional feature. Without the feature, state stays RUN permanently.

Optional Feature:
- Macro LOOP_BREAK_FLUSH_EN.
- Defined:
  - When a completion with res_break=1 produces ap_done&ap_return, the FIFO is flushed on the same edge (q_cnt=0).
  - If inflight after that completion is >0, state goes to DRAIN.
  - In DRAIN: ap_ready=0, work_valid=0, and remaining res_valid decrement inflight without asserting ap_done.
  - DRAIN returns to RUN the cycle after inflight reaches 0.
  - ap_start in the same cycle as the flushing edge is not accepted, because ap_ready is forced 0 when res_valid & res_break is present.
- Undefined: every completion reports ap_done, and queued indices continue to issue. Dropping further starts is left to the looper.

Decomposition:
- Package loop_resp_pkg holds:
  - state enum {RUN, DRAIN};
  - the default DEPTH constant;
  - an occupancy-width function.
- Sub-module loop_idx_fifo: synchronous FIFO, DEPTH x IDX_DWIDTH, with push, pop, flush, count, empty and full. It uses the same clk/rstn.
- The responder holds only the counters, the FSM and the output registers.

Test Plan:
- Single iteration, worker latency 3: ap_start=1 with ap_idx=7 at cycle 0. Expect work_valid, work_idx=7 at cycle 1; res_valid at cycle 4; ap_done=1, ap_return=0 at cycle 5; ap_idle=1 from cycle 6.
- Back-to-back, DEPTH=4, work_ready=0: 5 consecutive starts with indices 0..4. Expect 4 accepted, ap_ready=0 while occupancy=4. After work_ready=1 and one res_valid, ap_ready=1 and index 4 is accepted.
- Simultaneous events: accept, issue and complete in one cycle with occupancy=2. Expect occupancy stays 2 and the FIFO order is preserved (work_idx sequence 10,11,12).
- Stray result: res_valid with inflight=0. Expect no ap_done, occupancy=0, ap_idle=1.
- Reset mid-run: rstn=0 for 1 cycle with occupancy=3. Expect occupancy=0, ap_ready=1, work_valid=0. A late res_valid produces no ap_done.
- LOOP_BREAK_FLUSH_EN: 2 in flight, 2 queued, first result has res_break=1. Expect ap_done&ap_return once, q_cnt=0, state DRAIN. The second result is suppressed, then RUN and ap_idle=1.
